// File: rtl/wrr_arbiter_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM state
// encoding and the grant-index width helper.
package wrr_arbiter_pkg;

  // Two-state controller: nobody holds the resource, or one requester does.
  typedef logic [0:0] state_t;
  localparam state_t STATE_IDLE  = 1'b0;
  localparam state_t STATE_GRANT = 1'b1;

  // Width of a requester index. A single requester still gets a 1-bit index
  // so that the grant-id port never collapses to zero width.
  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between the requesters (master side) and the
// arbiter (slave side). Clock and reset travel as plain ports.
interface wrr_arbiter_if
  import wrr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int WW = 4
) ();

  localparam int IDW = calc_idw(N);

  logic [N-1:0]    req;        // request level per requester
  logic [N*WW-1:0] weight;     // transactions per turn, WW bits per requester
  logic            done;       // one-cycle pulse: granted transaction finished
  logic [N-1:0]    gnt;        // one-hot grant
  logic [IDW-1:0]  gnt_id;     // index of the granted requester
  logic            gnt_valid;  // any grant active

  // Requester / resource side drives requests and completion.
  modport master (
    output req,
    output weight,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid
  );

  // Arbiter side consumes requests and drives the grant.
  modport slave (
    input  req,
    input  weight,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid
  );

endinterface

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating priority encoder: finds the first asserted request scanning
// ptr+1, ptr+2, ... ptr+N (mod N), so the pointer itself is checked last.
module rr_pick
  import wrr_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           hit,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   onehot
);

  // Scan from the farthest offset down to the nearest one so that the
  // nearest asserted request after ptr overwrites any farther candidate.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = N; k >= 1; k--) begin
      int pos;
      pos = (int'(ptr) + k) % N;
      if (req[pos]) begin
        hit         = 1'b1;
        idx         = IDW'(pos);
        onehot      = '0;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter. A requester keeps the grant for up to its
// weight in completed transactions, or until it drops its request; the
// grant then rotates to the next requester after it, with no idle cycle.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input logic          clk,
  input logic          rstn,
  wrr_arbiter_if.slave bus
);

  localparam int IDW = calc_idw(N);

  // Registered state
  state_t         state_reg,     state_next;
  logic [WW-1:0]  credit_reg,    credit_next;
  logic [IDW-1:0] ptr_reg,       ptr_next;
  logic [N-1:0]   gnt_reg,       gnt_next;
  logic [IDW-1:0] gnt_id_reg,    gnt_id_next;
  logic           gnt_valid_reg, gnt_valid_next;

  // Search result and helpers
  logic [WW-1:0]  weight_arr [N];
  logic [IDW-1:0] pick_ptr;
  logic           pick_hit;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;
  logic [WW-1:0]  pick_weight;
  logic [WW-1:0]  load_credit;
  logic           holder_req;
  logic           release_now;

  // Unpack the flat weight bus into one field per requester.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_weight
      assign weight_arr[gi] = bus.weight[gi*WW +: WW];
    end
  endgenerate

  // While a grant is held, the search for the successor starts right after
  // the holder, so a release can hand over in the same cycle.
  assign pick_ptr = (state_reg == STATE_GRANT) ? gnt_id_reg : ptr_reg;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (pick_ptr),
    .hit    (pick_hit),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // A weight of zero still buys one transaction, so credit never starts at 0.
  assign pick_weight = weight_arr[pick_idx];
  assign load_credit = (pick_weight == '0) ? WW'(1) : pick_weight;

  // The holder gives up the grant on its last credited completion or as soon
  // as it withdraws its request; both together are simply a release.
  assign holder_req  = bus.req[gnt_id_reg];
  assign release_now = (state_reg == STATE_GRANT) &&
                       ((bus.done && (credit_reg == WW'(1))) || !holder_req);

  // State register: FSM state, pointer, credit and the registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= STATE_IDLE;
      credit_reg    <= '0;
      ptr_reg       <= IDW'(N - 1);
      gnt_reg       <= '0;
      gnt_id_reg    <= '0;
      gnt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      credit_reg    <= credit_next;
      ptr_reg       <= ptr_next;
      gnt_reg       <= gnt_next;
      gnt_id_reg    <= gnt_id_next;
      gnt_valid_reg <= gnt_valid_next;
    end
  end

  // Next-state logic: grant loading, credit accounting and rotation.
  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    ptr_next    = ptr_reg;
    gnt_next    = gnt_reg;
    gnt_id_next = gnt_id_reg;

    case (state_reg)
      STATE_IDLE: begin
        // DONE has no meaning without a holder and is ignored here.
        if (pick_hit) begin
          state_next  = STATE_GRANT;
          gnt_next    = pick_onehot;
          gnt_id_next = pick_idx;
          credit_next = load_credit;
        end
      end

      STATE_GRANT: begin
        if (release_now) begin
          ptr_next = gnt_id_reg;
          if (pick_hit) begin
            // Winner may be the same holder when nobody else is asking.
            gnt_next    = pick_onehot;
            gnt_id_next = pick_idx;
            credit_next = load_credit;
          end else begin
            state_next  = STATE_IDLE;
            gnt_next    = '0;
            gnt_id_next = '0;
            credit_next = '0;
          end
        end else if (bus.done && (credit_reg > WW'(1))) begin
          credit_next = credit_reg - WW'(1);
        end
      end

      default: begin
        state_next  = STATE_IDLE;
        gnt_next    = '0;
        gnt_id_next = '0;
        credit_next = '0;
      end
    endcase

    gnt_valid_next = |gnt_next;
  end

  // Output logic: the bus sees only registered values.
  always_comb begin
    bus.gnt       = gnt_reg;
    bus.gnt_id    = gnt_id_reg;
    bus.gnt_valid = gnt_valid_reg;
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed scoreboard bench for wrr_arbiter (N=4, WW=4). Stimulus pushes the
// expected grant for the cycle it targets; a monitor on the falling edge pops
// and compares whatever entries are due.
module tb_wrr_arbiter;
  import wrr_arbiter_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  wrr_arbiter_if #(.N(4), .WW(4)) bus ();

  wrr_arbiter #(.N(4), .WW(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] gnt;
    logic       chk_credit;
    logic [3:0] credit;
    logic       chk_ptr;
    logic [1:0] ptr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] id_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: compare every scoreboard entry due at this falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      logic ok;
      mon_e = sb.pop_front();
      checks++;
      ok = (mon_e.cyc == cyc) &&
           (bus.gnt === mon_e.gnt) &&
           (bus.gnt_id === id_of(mon_e.gnt)) &&
           (bus.gnt_valid === (|mon_e.gnt)) &&
           (!mon_e.chk_credit || (dut.credit_reg === mon_e.credit)) &&
           (!mon_e.chk_ptr || (dut.ptr_reg === mon_e.ptr));
      if (ok) begin
        $display("cyc %0d %s: gnt=%b id=%0d valid=%b credit=%0d ptr=%0d ok",
                 cyc, mon_e.name, bus.gnt, bus.gnt_id, bus.gnt_valid,
                 dut.credit_reg, dut.ptr_reg);
      end else begin
        errors++;
        $display("FAIL %s: cyc %0d got gnt=%b id=%0d valid=%b credit=%0d ptr=%0d, expected gnt=%b id=%0d valid=%b credit=%0d(chk %0b) ptr=%0d(chk %0b) at cyc %0d",
                 mon_e.name, cyc, bus.gnt, bus.gnt_id, bus.gnt_valid,
                 dut.credit_reg, dut.ptr_reg, mon_e.gnt, id_of(mon_e.gnt),
                 |mon_e.gnt, mon_e.credit, mon_e.chk_credit, mon_e.ptr,
                 mon_e.chk_ptr, mon_e.cyc);
      end
    end
  end

  // Drive one cycle of inputs and queue the grant expected after the next edge.
  task automatic drive(input string name, input logic [3:0] req, input logic done,
                       input logic [3:0] exp_gnt,
                       input logic chk_c = 1'b0, input logic [3:0] exp_c = 4'd0,
                       input logic chk_p = 1'b0, input logic [1:0] exp_p = 2'd0);
    exp_t e;
    @(negedge clk);
    #2;
    bus.req  = req;
    bus.done = done;
    e.cyc        = cyc + 1;
    e.name       = name;
    e.gnt        = exp_gnt;
    e.chk_credit = chk_c;
    e.credit     = exp_c;
    e.chk_ptr    = chk_p;
    e.ptr        = exp_p;
    sb.push_back(e);
  endtask

  // Immediate check that all outputs are cleared (used while reset is low).
  task automatic check_zero(input string name);
    checks++;
    if (bus.gnt !== 4'b0 || bus.gnt_id !== 2'd0 || bus.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b, expected all zero",
               name, bus.gnt, bus.gnt_id, bus.gnt_valid);
    end else begin
      $display("%s: outputs zero ok", name);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #1;
    rstn     = 1'b0;
    bus.req  = 4'b0;
    bus.done = 1'b0;
    #1;
    check_zero(name);
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    bus.req    = 4'b0;
    bus.done   = 1'b0;
    bus.weight = 16'h1111;

    // 1: outputs stay zero under reset even with a request and a clock edge.
    rstn    = 1'b0;
    bus.req = 4'b0001;
    @(negedge clk);
    check_zero("t1_rst_held");
    bus.req = 4'b0000;
    #1 rstn = 1'b1;
    drive("t1_first", 4'b0001, 1'b0, 4'b0001, 1'b1, 4'd1, 1'b1, 2'd3);

    // 2: equal weights, DONE every cycle -> one grant each, no gaps.
    bus.weight = 16'h1111;
    do_reset("t2_rst");
    drive("t2_g0",  4'b1111, 1'b1, 4'b0001);
    drive("t2_g1",  4'b1111, 1'b1, 4'b0010);
    drive("t2_g2",  4'b1111, 1'b1, 4'b0100);
    drive("t2_g3",  4'b1111, 1'b1, 4'b1000);
    drive("t2_g0b", 4'b1111, 1'b1, 4'b0001);

    // 3: requester 0 weight 3 holds for three completions.
    bus.weight = 16'h1113;
    do_reset("t3_rst");
    drive("t3_g0a", 4'b1111, 1'b1, 4'b0001, 1'b1, 4'd3);
    drive("t3_g0b", 4'b1111, 1'b1, 4'b0001, 1'b1, 4'd2);
    drive("t3_g0c", 4'b1111, 1'b1, 4'b0001, 1'b1, 4'd1);
    drive("t3_g1",  4'b1111, 1'b1, 4'b0010);
    drive("t3_g2",  4'b1111, 1'b1, 4'b0100);
    drive("t3_g3",  4'b1111, 1'b1, 4'b1000);

    // 4: holder withdraws without DONE -> immediate handover, ptr = old holder.
    bus.weight = 16'h1111;
    do_reset("t4_rst");
    drive("t4_g2",      4'b0100, 1'b0, 4'b0100);
    drive("t4_drop",    4'b1011, 1'b0, 4'b1000, 1'b0, 4'd0, 1'b1, 2'd2);
    drive("t4_wrap",    4'b1011, 1'b1, 4'b0001, 1'b0, 4'd0, 1'b1, 2'd3);

    // 5: sole requester re-wins; zero weight grants exactly one transaction.
    bus.weight = 16'h0020;
    do_reset("t5_rst");
    drive("t5_c2a",  4'b0010, 1'b1, 4'b0010, 1'b1, 4'd2);
    drive("t5_c1a",  4'b0010, 1'b1, 4'b0010, 1'b1, 4'd1);
    drive("t5_c2b",  4'b0010, 1'b1, 4'b0010, 1'b1, 4'd2);
    drive("t5_c1b",  4'b0010, 1'b1, 4'b0010, 1'b1, 4'd1);
    drive("t5_w0_g2", 4'b0101, 1'b1, 4'b0100, 1'b1, 4'd1);
    drive("t5_w0_g0", 4'b0101, 1'b1, 4'b0001, 1'b1, 4'd1);

    // 6: async reset mid-grant, restart from requester 0, withdraw to IDLE.
    bus.weight = 16'h1111;
    do_reset("t6_rst");
    drive("t6_g3", 4'b1000, 1'b0, 4'b1000);
    @(negedge clk);
    #1;
    rstn     = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #1;
    check_zero("t6_async_rst");
    #1 rstn = 1'b1;
    drive("t6_restart", 4'b1010, 1'b0, 4'b0010);
    drive("t6_idle",    4'b0000, 1'b0, 4'b0000, 1'b1, 4'd0, 1'b1, 2'd1);
    drive("t6_stay",    4'b0000, 1'b1, 4'b0000);
    drive("t6_reload",  4'b0001, 1'b0, 4'b0001);

    // Drain: every queued expectation must have been consumed.
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
